// File: rtl/psc_tx_frame_scheduler_if.sv
// Handshake/bus bundle between the PSC trigger-link transmit scheduler and its environment.
// The slave modport is the scheduler's view; the master modport is the driver's view.
interface psc_tx_frame_scheduler_if;
  logic       enable;
  logic       trig_req;
  logic       stat_req;
  logic       bit_tick;
  logic       load;
  logic [3:0] rom_addr;
  logic       is_trigger;
  logic       frame_active;
  logic       trig_pending;
  logic [7:0] overrun_cnt;

  modport master (
    output enable, trig_req, stat_req,
    input  bit_tick, load, rom_addr, is_trigger, frame_active, trig_pending, overrun_cnt
  );

  modport slave (
    input  enable, trig_req, stat_req,
    output bit_tick, load, rom_addr, is_trigger, frame_active, trig_pending, overrun_cnt
  );
endinterface

// File: rtl/psc_tx_frame_scheduler.sv
// Single-clock transmit scheduler for the PSC trigger link: bit/word timing via clock
// enables, and trigger-over-status frame arbitration driving the data-ROM address.
module psc_tx_frame_scheduler #(
  parameter int unsigned BIT_DIV     = 5,
  parameter int unsigned WORD_BITS   = 10,
  parameter int unsigned FRAME_WORDS = 8,
  parameter int unsigned IDLE_GAP    = 2
) (
  input logic                     clk,
  input logic                     reset,
  psc_tx_frame_scheduler_if.slave bus
);

  localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP - 1);
  localparam logic [3:0]       ADDR_LAST = 4'(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [1:0]       trig_sync_r;
  logic [1:0]       stat_sync_r;
  logic             trig_prev_r;
  logic             stat_prev_r;
  logic             trig_edge_s;
  logic             stat_edge_s;

  logic             trig_pending_r;
  logic             stat_pending_r;
  logic [7:0]       overrun_r;

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [BIT_W-1:0] bit_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;
  logic             load_r;
  logic             load_nxt_s;

  state_t           state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [3:0]       rom_addr_r;
  logic             is_trigger_r;
  logic             frame_active_r;

  logic             boundary_s;
  logic             start_trig_s;
  logic             start_stat_s;

  // Request synchronizers and rising-edge history; these run regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_sync_r <= 2'b00;
      stat_sync_r <= 2'b00;
      trig_prev_r <= 1'b0;
      stat_prev_r <= 1'b0;
    end else begin
      trig_sync_r <= {trig_sync_r[0], bus.trig_req};
      stat_sync_r <= {stat_sync_r[0], bus.stat_req};
      trig_prev_r <= trig_sync_r[1];
      stat_prev_r <= stat_sync_r[1];
    end
  end

  assign trig_edge_s = trig_sync_r[1] & ~trig_prev_r;
  assign stat_edge_s = stat_sync_r[1] & ~stat_prev_r;

  // Next-state of the bit/word timebase; tick and load are precomputed so they leave a flop.
  always_comb begin
    div_nxt_s  = '0;
    bit_nxt_s  = '0;
    tick_nxt_s = 1'b0;
    load_nxt_s = 1'b0;
    if (bus.enable) begin
      if (div_cnt_r == DIV_LAST) begin
        div_nxt_s = '0;
      end else begin
        div_nxt_s = div_cnt_r + DIV_W'(1);
      end
      if (tick_r) begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_nxt_s = '0;
        end else begin
          bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end
      end else begin
        bit_nxt_s = bit_cnt_r;
      end
      tick_nxt_s = (div_nxt_s == DIV_LAST);
      load_nxt_s = tick_nxt_s && (bit_nxt_s == BIT_LAST);
    end else begin
      div_nxt_s  = '0;
      bit_nxt_s  = '0;
      tick_nxt_s = 1'b0;
      load_nxt_s = 1'b0;
    end
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      tick_r    <= 1'b0;
      load_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      bit_cnt_r <= bit_nxt_s;
      tick_r    <= tick_nxt_s;
      load_r    <= load_nxt_s;
    end
  end

  assign boundary_s   = bus.enable && load_r;
  assign start_trig_s = boundary_s && (state_r == ST_IDLE) && trig_pending_r;
  assign start_stat_s = boundary_s && (state_r == ST_IDLE) && !trig_pending_r && stat_pending_r;

  // Pending flags and overrun counter; a new edge wins over a clear in the same clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_pending_r <= 1'b0;
      stat_pending_r <= 1'b0;
      overrun_r      <= 8'd0;
    end else begin
      if (trig_edge_s) begin
        trig_pending_r <= 1'b1;
      end else if (start_trig_s) begin
        trig_pending_r <= 1'b0;
      end else begin
        trig_pending_r <= trig_pending_r;
      end
      if (stat_edge_s) begin
        stat_pending_r <= 1'b1;
      end else if (start_stat_s) begin
        stat_pending_r <= 1'b0;
      end else begin
        stat_pending_r <= stat_pending_r;
      end
      if (trig_edge_s && trig_pending_r && !start_trig_s && (overrun_r != 8'hFF)) begin
        overrun_r <= overrun_r + 8'd1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Frame FSM; transitions only on the load cycle, outputs registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      gap_cnt_r      <= '0;
      rom_addr_r     <= 4'd0;
      is_trigger_r   <= 1'b0;
      frame_active_r <= 1'b0;
    end else if (!bus.enable) begin
      state_r        <= ST_IDLE;
      gap_cnt_r      <= '0;
      rom_addr_r     <= 4'd0;
      is_trigger_r   <= 1'b0;
      frame_active_r <= 1'b0;
    end else if (load_r) begin
      case (state_r)
        ST_IDLE: begin
          if (start_trig_s || start_stat_s) begin
            state_r        <= ST_FRAME;
            rom_addr_r     <= 4'd1;
            is_trigger_r   <= start_trig_s;
            frame_active_r <= 1'b1;
          end else begin
            state_r        <= ST_IDLE;
            rom_addr_r     <= 4'd0;
            is_trigger_r   <= 1'b0;
            frame_active_r <= 1'b0;
          end
          gap_cnt_r <= '0;
        end
        ST_FRAME: begin
          if (rom_addr_r == ADDR_LAST) begin
            state_r        <= ST_GAP;
            rom_addr_r     <= 4'd0;
            is_trigger_r   <= 1'b0;
            frame_active_r <= 1'b0;
            gap_cnt_r      <= '0;
          end else begin
            rom_addr_r <= rom_addr_r + 4'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= '0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          gap_cnt_r      <= '0;
          rom_addr_r     <= 4'd0;
          is_trigger_r   <= 1'b0;
          frame_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_tick     = tick_r;
  assign bus.load         = load_r;
  assign bus.rom_addr     = rom_addr_r;
  assign bus.is_trigger   = is_trigger_r;
  assign bus.frame_active = frame_active_r;
  assign bus.trig_pending = trig_pending_r;
  assign bus.overrun_cnt  = overrun_r;

endmodule

// File: tb/tb_psc_tx_frame_scheduler.sv
// Self-checking bench for psc_tx_frame_scheduler: directed scenarios plus random requests,
// compared every clock against a behavioural model built from enabled-cycle arithmetic.
module tb_psc_tx_frame_scheduler;
  localparam int BD   = 5;
  localparam int WB   = 10;
  localparam int FW   = 8;
  localparam int IG   = 2;
  localparam int WORD = BD * WB;

  logic clk;
  logic reset;
  psc_tx_frame_scheduler_if bus();

  psc_tx_frame_scheduler #(
    .BIT_DIV(BD), .WORD_BITS(WB), .FRAME_WORDS(FW), .IDLE_GAP(IG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks;
  int failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: enabled-edge count, position within a frame (-1 idle), request history.
  int en_cnt;
  int pos;
  bit ftrig;
  bit tpend;
  bit spend;
  int ov;
  bit th[3];
  bit sh[3];

  initial begin : model_and_compare
    bit boundary, tedge, sedge, st_t, st_s, act;
    en_cnt = 0; pos = -1; ftrig = 0; tpend = 0; spend = 0; ov = 0;
    for (int i = 0; i < 3; i++) begin th[i] = 0; sh[i] = 0; end
    forever begin
      @(posedge clk);
      if (!reset) begin
        en_cnt = 0; pos = -1; ftrig = 0; tpend = 0; spend = 0; ov = 0;
        for (int i = 0; i < 3; i++) begin th[i] = 0; sh[i] = 0; end
      end else begin
        boundary = bus.enable && (en_cnt % WORD == WORD - 1);
        tedge = th[1] && !th[2];
        sedge = sh[1] && !sh[2];
        st_t = boundary && (pos < 0) && tpend;
        st_s = boundary && (pos < 0) && !tpend && spend;
        if (tedge && tpend && !st_t && ov < 255) ov++;
        tpend = tedge ? 1'b1 : (st_t ? 1'b0 : tpend);
        spend = sedge ? 1'b1 : (st_s ? 1'b0 : spend);
        th[2] = th[1]; th[1] = th[0]; th[0] = bus.trig_req;
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = bus.stat_req;
        if (!bus.enable) begin
          en_cnt = 0;
          pos = -1;
        end else begin
          if (boundary) begin
            if (pos < 0) begin
              if (st_t || st_s) begin
                pos = 0;
                ftrig = st_t;
              end
            end else begin
              pos++;
              if (pos >= FW + IG) pos = -1;
            end
          end
          en_cnt++;
        end
      end
      #1;
      act = (pos >= 0) && (pos < FW);
      chk("m_bit_tick", int'(bus.bit_tick), int'(en_cnt % BD == BD - 1));
      chk("m_load", int'(bus.load), int'(en_cnt % WORD == WORD - 1));
      chk("m_rom_addr", int'(bus.rom_addr), act ? pos + 1 : 0);
      chk("m_frame_active", int'(bus.frame_active), int'(act));
      chk("m_is_trigger", int'(bus.is_trigger), int'(act && ftrig));
      chk("m_trig_pending", int'(bus.trig_pending), int'(tpend));
      chk("m_overrun_cnt", int'(bus.overrun_cnt), ov);
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0: return bus.bit_tick;
      1: return bus.load;
      2: return bus.frame_active;
      3: return bus.trig_pending;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input bit val, input int budget, input string name);
    int n;
    n = 0;
    while (sig(sel) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(sig(sel)), int'(val));
  endtask

  task automatic wait_addr(input int a, input int budget, input string name);
    int n;
    n = 0;
    while (int'(bus.rom_addr) != a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.rom_addr), a);
  endtask

  // Count negedges until sel reaches val (bounded).
  task automatic count_until(input int sel, input bit val, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(sel) != val && n < budget);
  endtask

  task automatic pulse(input bit is_trig, input int hi, input int lo);
    if (is_trig) bus.trig_req = 1'b1; else bus.stat_req = 1'b1;
    repeat (hi) @(negedge clk);
    if (is_trig) bus.trig_req = 1'b0; else bus.stat_req = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_tick"}, int'(bus.bit_tick), 0);
    chk({tag, "_load"}, int'(bus.load), 0);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_is_trigger"}, int'(bus.is_trigger), 0);
    chk({tag, "_frame_active"}, int'(bus.frame_active), 0);
    chk({tag, "_trig_pending"}, int'(bus.trig_pending), 0);
    chk({tag, "_overrun_cnt"}, int'(bus.overrun_cnt), 0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.trig_req = 1'b0;
    bus.stat_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Idle cadence.
    reset = 1'b1;
    bus.enable = 1'b1;
    wait_for(1, 1'b1, 120, "first_load");
    count_until(1, 1'b1, 100, n);
    chk("load_period", n, WORD);
    wait_for(0, 1'b1, 20, "tick_seen");
    count_until(0, 1'b1, 20, n);
    chk("tick_period", n, BD);

    // Single trigger.
    bus.trig_req = 1'b1;
    @(negedge clk);
    bus.trig_req = 1'b0;
    @(negedge clk);
    chk("trig_latency_2clk", int'(bus.trig_pending), 0);
    @(negedge clk);
    chk("trig_latency_3clk", int'(bus.trig_pending), 1);
    wait_for(2, 1'b1, 60, "trig_frame_start");
    chk("trig_frame_type", int'(bus.is_trigger), 1);
    chk("trig_first_addr", int'(bus.rom_addr), 1);
    count_until(2, 1'b0, 500, n);
    chk("frame_len", n, FW * WORD);
    chk("gap_addr", int'(bus.rom_addr), 0);
    repeat (150) @(negedge clk);

    // Priority: both requests in the same clock.
    bus.trig_req = 1'b1;
    bus.stat_req = 1'b1;
    @(negedge clk);
    bus.trig_req = 1'b0;
    bus.stat_req = 1'b0;
    wait_for(2, 1'b1, 120, "prio_first_start");
    chk("prio_first_is_trig", int'(bus.is_trigger), 1);
    wait_for(2, 1'b0, 450, "prio_first_end");
    count_until(2, 1'b1, 300, n);
    chk("prio_gap_plus_idle", n, (IG + 1) * WORD);
    chk("prio_second_is_stat", int'(bus.is_trigger), 0);
    wait_for(2, 1'b0, 450, "prio_second_end");
    repeat (200) @(negedge clk);

    // Overrun: three edges during one trigger frame.
    chk("ov_before", int'(bus.overrun_cnt), 0);
    pulse(1'b1, 1, 0);
    wait_for(2, 1'b1, 120, "ov_frame_start");
    repeat (3) pulse(1'b1, 2, 8);
    chk("ov_count_2", int'(bus.overrun_cnt), 2);
    chk("ov_pending", int'(bus.trig_pending), 1);
    wait_for(2, 1'b0, 450, "ov_frame_end");
    wait_for(2, 1'b1, 200, "ov_second_start");
    chk("ov_second_is_trig", int'(bus.is_trigger), 1);
    wait_for(2, 1'b0, 450, "ov_second_end");
    repeat (200) @(negedge clk);
    chk("ov_no_third_frame", int'(bus.frame_active), 0);
    chk("ov_no_pending", int'(bus.trig_pending), 0);

    // Saturation.
    repeat (300) pulse(1'b1, 3, 3);
    repeat (5) @(negedge clk);
    chk("ov_saturated", int'(bus.overrun_cnt), 255);

    // Async reset mid-frame.
    wait_for(2, 1'b0, 500, "rst_idle_before");
    repeat (120) @(negedge clk);
    pulse(1'b1, 1, 0);
    wait_addr(4, 300, "rst_reach_addr4");
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    chk("rst_no_pending", int'(bus.trig_pending), 0);
    chk("rst_no_frame", int'(bus.frame_active), 0);

    // Enable drop with status pending.
    pulse(1'b0, 1, 0);
    wait_for(2, 1'b1, 120, "en_stat_start");
    chk("en_stat_type", int'(bus.is_trigger), 0);
    pulse(1'b0, 1, 5);
    wait_addr(5, 300, "en_reach_addr5");
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_addr", int'(bus.rom_addr), 0);
    chk("en_off_active", int'(bus.frame_active), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n += int'(bus.bit_tick) + int'(bus.load);
    end
    chk("en_off_no_ticks", n, 0);
    bus.enable = 1'b1;
    count_until(2, 1'b1, 200, n);
    chk("en_restart_delay", n, WORD);
    chk("en_restart_addr", int'(bus.rom_addr), 1);
    chk("en_restart_type", int'(bus.is_trigger), 0);

    // Randomized requests, enable drops and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 1999) == 0) reset = 1'b0;
      if ($urandom_range(0, 99) < 2) bus.trig_req = ~bus.trig_req;
      if ($urandom_range(0, 99) < 2) bus.stat_req = ~bus.stat_req;
      if (bus.enable) begin
        if ($urandom_range(0, 999) < 3) bus.enable = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 5) bus.enable = 1'b1;
      end
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
